vlsu_axi_mem_slave: RTL
=======================

Name: vlsu_axi_mem_slave

Overview:
- AXI4 subordinate (responder) with an internal byte-addressed memory array.
- Pairs with the VLSU AXI master. It accepts AW/W and returns B, and accepts AR and returns R.
- Used as the memory endpoint in VLSU unit and subsystem benches, and as a simple on-chip scratchpad.
- Read and write paths are independent FSMs. Each path allows one outstanding burst.

Parameters:
- AxiDataWidth, 128, data bus width in bits; power of 2, at least 32.
- AxiAddrWidth, 32, address width in bits.
- AxiIdWidth, 4, ID width in bits.
- MemBytes, 65536, memory size in bytes; power of 2; based at address 0.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- s_axi_aw_valid_i, s_axi_aw_ready_o  in/out  1  AW handshake.
- s_axi_aw_id_i  in  AxiIdWidth  write ID.
- s_axi_aw_addr_i  in  AxiAddrWidth  start address.
- s_axi_aw_len_i  in  8  beats minus 1.
- s_axi_aw_size_i  in  3  log2 of bytes per beat.
- s_axi_aw_burst_i  in  2  burst type; 0 FIXED, 1 INCR, 2 WRAP.
- s_axi_w_valid_i, s_axi_w_ready_o  in/out  1  W handshake.
- s_axi_w_data_i  in  AxiDataWidth  write data.
- s_axi_w_strb_i  in  AxiDataWidth/8  byte strobes.
- s_axi_w_last_i  in  1  last write beat.
- s_axi_b_valid_o, s_axi_b_ready_i  out/in  1  B handshake.
- s_axi_b_id_o  out  AxiIdWidth  echoed AW ID.
- s_axi_b_resp_o  out  2  write response.
- s_axi_ar_valid_i, s_axi_ar_ready_o, s_axi_ar_id_i, s_axi_ar_addr_i, s_axi_ar_len_i, s_axi_ar_size_i, s_axi_ar_burst_i: same meanings and widths as the AW fields.
- s_axi_r_valid_o, s_axi_r_ready_i  out/in  1  R handshake.
- s_axi_r_id_o  out  AxiIdWidth  echoed AR ID.
- s_axi_r_data_o  out  AxiDataWidth  read data.
- s_axi_r_resp_o  out  2  read response.
- s_axi_r_last_o  out  1  last read beat.

Behaviour:
- Reset, checked at the clk_i edge with rst_ni=0:
  - Both FSMs go to IDLE.
  - All valid outputs are 0. aw_ready_o=1 and ar_ready_o=1. w_ready_o=0.
  - b/r id, resp, data and last outputs are 0.
  - Memory contents are not reset.
  - Reset mid-burst abandons the burst with no B/R issued and no further writes.
- Write FSM, states W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: aw_ready=1. On the AW handshake, latch id, addr, len, size and burst, set err=OKAY, and go to W_DATA.
  - W_DATA: aw_ready=0, w_ready=1.
  - Each W handshake with err=OKAY writes the bytes whose strb bit is 1 to the beat-aligned word at addr & ~(AxiDataWidth/8-1).
  - After each beat the address advances: INCR adds 2^size; FIXED holds.
  - On the beat with w_last, go to W_RESP.
  - W_RESP: b_valid=1 with the latched id and resp=err. On the B handshake go to W_IDLE.
- Read FSM, states R_IDLE -> R_DATA -> R_IDLE:
  - On the AR handshake in cycle t, latch the fields and register beat 0.
  - r_valid=1 from cycle t+1. r_data, id, resp and last are all registered.
  - Each R handshake loads the next beat into the register. r_last=1 on beat len.
  - The R handshake on the last beat returns the FSM to R_IDLE. ar_ready=1 only in R_IDLE.
- Error rules, decided at the A-channel handshake and reported on every beat:
  - burst=WRAP or reserved: SLVERR (2).
  - size > log2(AxiDataWidth/8): SLVERR.
  - Any beat address >= MemBytes: DECERR (3). Check with the end address computed as start + len·2^size for INCR, in AxiAddrWidth+9 bits so it cannot wrap.
  - On any error, writes are suppressed and read data is 0. w_last is still awaited, then B is issued.
- Crossing a 4 KiB boundary is not checked; the master guarantees it.
- Flow control: outputs stay stable while valid=1 and ready=0, per AXI.
- Reads and writes run concurrently.
- Read and write to the same word in the same cycle: the read register captures the pre-write value, and the write updates memory.
- W beats arriving before AW are held off (w_ready=0 in W_IDLE).
- A w_last that does not match len is not flagged. The FSM follows w_last and the response is the latched err.

Decomposition:
- Package vlsu_axi_mem_pkg holds:
  - Response encodings RESP_OKAY=0, RESP_SLVERR=2, RESP_DECERR=3.
  - Burst encodings.
  - Enums for write-FSM and read-FSM states.
  - Function next_beat_addr(addr, size, burst).
  - Function burst_err(addr, len, size, burst, MemBytes).
- One sub-module, vlsu_axi_mem_array: byte-strobed write port plus registered read port, word-addressed, depth MemBytes/(AxiDataWidth/8).

Test Plan:
- Single-beat INCR write then read: AW addr=0x100, len=0, size=4, id=3; W data=0xA5..A5, strb all ones -> B id=3, resp=0. AR addr=0x100 -> R at t+1 with data=0xA5..A5, last=1, resp=0.
- 4-beat INCR read with r_ready held 0 for 3 cycles on beat 1 -> r_data and r_last stable while stalled; beats return words 0x100..0x130; r_last only on beat 3.
- Partial strobe: write strb=0x0001 data=0xFF to 0x200 over memory pre-filled with 0x11 -> readback byte 0 is 0xFF, other bytes 0x11.
- Error cases:
  - AR burst=WRAP len=3 -> 4 beats, resp=2, data=0, last on beat 3.
  - AW addr=MemBytes-16, len=1, size=4 -> B resp=3 and memory unchanged.
- Concurrent traffic: AW/W to 0x300 and AR to 0x300 in the same cycle as the write beat -> R returns the old data; a second AR returns the new data.
- Reset asserted during W_DATA beat 2 of 4 -> next cycle aw_ready=1, w_ready=0, b_valid=0; a new transaction completes normally.

Source files
------------

// File: rtl/vlsu_axi_mem_pkg.sv
// Shared encodings, FSM states and address/error helpers for the AXI memory slave.
// Helpers work on 64-bit addresses so the burst end address never wraps.
package vlsu_axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    function automatic logic [63:0] next_beat_addr(input logic [63:0] addr,
                                                   input logic [2:0]  size,
                                                   input logic [1:0]  burst);
        if (burst == BURST_FIXED) return addr;
        return addr + (64'd1 << size);
    endfunction

    function automatic logic [1:0] burst_err(input logic [63:0] addr,
                                             input logic [7:0]  len,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst,
                                             input logic [63:0] mem_bytes,
                                             input logic [2:0]  max_size);
        logic [63:0] last_addr;
        last_addr = addr;
        if (burst == BURST_INCR) last_addr = addr + (64'(len) << size);
        if (burst == BURST_WRAP || burst == BURST_RSVD) return RESP_SLVERR;
        if (size > max_size)                            return RESP_SLVERR;
        if (last_addr >= mem_bytes)                     return RESP_DECERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/vlsu_axi_mem_array.sv
// Word-addressed memory with byte-strobed write port and registered read port.
// Latency: read data valid one cycle after rd_en; same-word read/write returns the old word.
// Backpressure: none; rd_dat holds its value while rd_en is low.
module vlsu_axi_mem_array #(
    parameter  int unsigned DataWidth = 128,
    parameter  int unsigned Depth     = 4096,
    localparam int unsigned AddrW     = $clog2(Depth),
    localparam int unsigned StrbW     = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en,
    input  logic [AddrW-1:0]     wr_addr,
    input  logic [DataWidth-1:0] wr_dat,
    input  logic [StrbW-1:0]     wr_strb,
    input  logic                 rd_en,
    input  logic [AddrW-1:0]     rd_addr,
    output logic [DataWidth-1:0] rd_dat
);

    logic [DataWidth-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < StrbW; b++) begin
            if (wr_en && wr_strb[b]) mem[wr_addr][b*8 +: 8] <= wr_dat[b*8 +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)    rd_dat <= '0;
        else if (rd_en) rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/vlsu_axi_mem_slave.sv
// AXI4 subordinate backed by an on-chip byte-addressed memory; one burst per direction.
// Latency: R beat 0 valid the cycle after AR; B valid the cycle after the last W beat.
// Backpressure: all outputs hold while valid && !ready; W held off until AW is accepted.
module vlsu_axi_mem_slave
    import vlsu_axi_mem_pkg::*;
#(
    parameter int unsigned AxiDataWidth = 128,
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned MemBytes     = 65536
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      s_axi_aw_valid_i,
    output logic                      s_axi_aw_ready_o,
    input  logic [AxiIdWidth-1:0]     s_axi_aw_id_i,
    input  logic [AxiAddrWidth-1:0]   s_axi_aw_addr_i,
    input  logic [7:0]                s_axi_aw_len_i,
    input  logic [2:0]                s_axi_aw_size_i,
    input  logic [1:0]                s_axi_aw_burst_i,
    input  logic                      s_axi_w_valid_i,
    output logic                      s_axi_w_ready_o,
    input  logic [AxiDataWidth-1:0]   s_axi_w_data_i,
    input  logic [AxiDataWidth/8-1:0] s_axi_w_strb_i,
    input  logic                      s_axi_w_last_i,
    output logic                      s_axi_b_valid_o,
    input  logic                      s_axi_b_ready_i,
    output logic [AxiIdWidth-1:0]     s_axi_b_id_o,
    output logic [1:0]                s_axi_b_resp_o,
    input  logic                      s_axi_ar_valid_i,
    output logic                      s_axi_ar_ready_o,
    input  logic [AxiIdWidth-1:0]     s_axi_ar_id_i,
    input  logic [AxiAddrWidth-1:0]   s_axi_ar_addr_i,
    input  logic [7:0]                s_axi_ar_len_i,
    input  logic [2:0]                s_axi_ar_size_i,
    input  logic [1:0]                s_axi_ar_burst_i,
    output logic                      s_axi_r_valid_o,
    input  logic                      s_axi_r_ready_i,
    output logic [AxiIdWidth-1:0]     s_axi_r_id_o,
    output logic [AxiDataWidth-1:0]   s_axi_r_data_o,
    output logic [1:0]                s_axi_r_resp_o,
    output logic                      s_axi_r_last_o
);

    localparam int unsigned StrbW    = AxiDataWidth / 8;
    localparam int unsigned OffW     = $clog2(StrbW);
    localparam int unsigned Depth    = MemBytes / StrbW;
    localparam int unsigned WordW    = $clog2(Depth);
    localparam logic [2:0]  MaxSize  = 3'(OffW);
    localparam logic [63:0] MemLimit = 64'(MemBytes);

    typedef struct packed {
        logic [AxiAddrWidth-1:0] addr;
        logic [2:0]              size;
        logic [1:0]              burst;
    } beat_ctl_t;

    // ---------------- write path ----------------
    w_state_e              w_state_q;
    beat_ctl_t             wr_q;
    logic                  aw_ready_q, w_ready_q, b_valid_q;
    logic [AxiIdWidth-1:0] b_id_q;
    logic [1:0]            b_resp_q;
    logic [1:0]            aw_err;
    logic                  aw_hs, w_hs, wr_en;

    assign aw_err = burst_err(64'(s_axi_aw_addr_i), s_axi_aw_len_i, s_axi_aw_size_i,
                              s_axi_aw_burst_i, MemLimit, MaxSize);
    assign aw_hs  = s_axi_aw_valid_i && aw_ready_q;
    assign w_hs   = s_axi_w_valid_i && w_ready_q;
    // b_resp_q carries the error latched at AW; a reset edge must not commit a pending beat.
    assign wr_en  = rst_ni && (w_state_q == W_DATA) && w_hs && (b_resp_q == RESP_OKAY);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            w_state_q  <= W_IDLE;
            wr_q       <= '0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: if (aw_hs) begin
                    wr_q       <= '{addr: s_axi_aw_addr_i, size: s_axi_aw_size_i, burst: s_axi_aw_burst_i};
                    b_id_q     <= s_axi_aw_id_i;
                    b_resp_q   <= aw_err;
                    aw_ready_q <= 1'b0;
                    w_ready_q  <= 1'b1;
                    w_state_q  <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    wr_q.addr <= AxiAddrWidth'(next_beat_addr(64'(wr_q.addr), wr_q.size, wr_q.burst));
                    if (s_axi_w_last_i) begin
                        w_ready_q <= 1'b0;
                        b_valid_q <= 1'b1;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: if (s_axi_b_ready_i) begin
                    b_valid_q  <= 1'b0;
                    aw_ready_q <= 1'b1;
                    w_state_q  <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    r_state_e              r_state_q;
    beat_ctl_t             rd_q;
    logic [7:0]            rd_len_q, rd_cnt_q;
    logic                  ar_ready_q, r_valid_q, r_last_q;
    logic [AxiIdWidth-1:0] r_id_q;
    logic [1:0]            r_resp_q;
    logic [1:0]            ar_err;
    logic                  ar_hs, r_hs, rd_en;
    logic [WordW-1:0]      rd_word;
    logic [AxiDataWidth-1:0] rd_dat;

    assign ar_err = burst_err(64'(s_axi_ar_addr_i), s_axi_ar_len_i, s_axi_ar_size_i,
                              s_axi_ar_burst_i, MemLimit, MaxSize);
    assign ar_hs  = s_axi_ar_valid_i && ar_ready_q;
    assign r_hs   = r_valid_q && s_axi_r_ready_i;

    // rd_q.addr always points at the beat after the one sitting in the output register.
    always_comb begin
        rd_en   = 1'b0;
        rd_word = rd_q.addr[OffW +: WordW];
        if (r_state_q == R_IDLE && ar_hs) begin
            rd_en   = 1'b1;
            rd_word = s_axi_ar_addr_i[OffW +: WordW];
        end else if (r_state_q == R_DATA && r_hs && !r_last_q) begin
            rd_en = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state_q  <= R_IDLE;
            rd_q       <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_id_q     <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: if (ar_hs) begin
                    rd_q       <= '{addr:  AxiAddrWidth'(next_beat_addr(64'(s_axi_ar_addr_i),
                                                                        s_axi_ar_size_i, s_axi_ar_burst_i)),
                                    size:  s_axi_ar_size_i,
                                    burst: s_axi_ar_burst_i};
                    rd_len_q   <= s_axi_ar_len_i;
                    rd_cnt_q   <= '0;
                    ar_ready_q <= 1'b0;
                    r_valid_q  <= 1'b1;
                    r_last_q   <= (s_axi_ar_len_i == 8'd0);
                    r_id_q     <= s_axi_ar_id_i;
                    r_resp_q   <= ar_err;
                    r_state_q  <= R_DATA;
                end
                R_DATA: if (r_hs) begin
                    if (r_last_q) begin
                        r_valid_q  <= 1'b0;
                        r_last_q   <= 1'b0;
                        ar_ready_q <= 1'b1;
                        r_state_q  <= R_IDLE;
                    end else begin
                        rd_cnt_q  <= rd_cnt_q + 8'd1;
                        r_last_q  <= (rd_cnt_q + 8'd1 == rd_len_q);
                        rd_q.addr <= AxiAddrWidth'(next_beat_addr(64'(rd_q.addr), rd_q.size, rd_q.burst));
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    vlsu_axi_mem_array #(
        .DataWidth (AxiDataWidth),
        .Depth     (Depth)
    ) u_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_en   (wr_en),
        .wr_addr (wr_q.addr[OffW +: WordW]),
        .wr_dat  (s_axi_w_data_i),
        .wr_strb (s_axi_w_strb_i),
        .rd_en   (rd_en),
        .rd_addr (rd_word),
        .rd_dat  (rd_dat)
    );

    assign s_axi_aw_ready_o = aw_ready_q;
    assign s_axi_w_ready_o  = w_ready_q;
    assign s_axi_b_valid_o  = b_valid_q;
    assign s_axi_b_id_o     = b_id_q;
    assign s_axi_b_resp_o   = b_resp_q;
    assign s_axi_ar_ready_o = ar_ready_q;
    assign s_axi_r_valid_o  = r_valid_q;
    assign s_axi_r_id_o     = r_id_q;
    assign s_axi_r_resp_o   = r_resp_q;
    assign s_axi_r_last_o   = r_last_q;
    // Errored bursts return zero data regardless of what the array produced.
    assign s_axi_r_data_o   = (r_resp_q == RESP_OKAY) ? rd_dat : '0;

endmodule
